// File: rtl/rr_ring_arbiter_if.sv
// Request/grant bundle for rr_ring_arbiter. With ARB_LOCK_EN defined it also carries
// the lock input.
interface rr_ring_arbiter_if #(
  parameter int N = 3
) ();
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic         busy;
  logic         z1;
`ifdef ARB_LOCK_EN
  logic         lock;

  modport master (output req, output done, output lock, input gnt, input busy, input z1);
  modport slave  (input req, input done, input lock, output gnt, output busy, output z1);
`else
  modport master (output req, output done, input gnt, input busy, input z1);
  modport slave  (input req, input done, output gnt, output busy, output z1);
`endif
endinterface

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring and a per-grant hold timeout.
// Optional feature: define ARB_LOCK_EN to add bus.lock, which suppresses the timeout.
module rr_ring_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  rr_ring_arbiter_if.slave bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [N-1:0]  pick;
  logic [N-1:0]  cand;
  logic          found;
  logic          timeout;
  logic          release_g;

  // Circular scan: rotate the one-hot candidate from ptr upward, first requester wins.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    pick  = '0;
    found = 1'b0;
    cand  = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && |(cand & bus.req)) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = {cand[N-2:0], cand[N-1]};
    end
  end

`ifdef ARB_LOCK_EN
  assign timeout = (hold_q == MAX_HOLD_C) && !bus.lock;
`else
  assign timeout = (hold_q == MAX_HOLD_C);
`endif

  // Requests and done pulses from non-granted lines are deliberately masked off.
  assign release_g = |(gnt_q & bus.done) || !(|(gnt_q & bus.req)) || timeout;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = pick;
          busy_d  = 1'b1;
          hold_d  = HW'(1);
          state_d = GRANT;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_g) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = {gnt_q[N-2:0], gnt_q[N-1]};
          hold_d  = '0;
          state_d = IDLE;
        end else if (hold_q != MAX_HOLD_C) begin
          // Saturation only matters while lock holds the grant past MAX_HOLD.
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments; the async reset clears gnt without waiting for an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= {{(N-1){1'b0}}, 1'b1};
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.z1   = |(gnt_q & (gnt_q - {{(N-1){1'b0}}, 1'b1}));

endmodule
